// File: rtl/oper_start_in_pipe.sv
// rtl/oper_start_in_pipe.sv - elastic FP add/sub operand ordering stage (capture + result register)
module oper_start_in_pipe #(
  parameter int W  = 32,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          add_subt_i,
  input  logic [W-1:0]  Data_X_i,
  input  logic [W-1:0]  Data_Y_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-2:0]  DMP_o,
  output logic [W-2:0]  DmP_o,
  output logic [EW-1:0] exp_diff_o,
  output logic          zero_flag_o,
  output logic          real_op_o,
  output logic          sign_final_result_o,
  output logic          special_o
);

  // capture stage contents
  logic         s1_valid;
  logic [W-1:0] s1_x;
  logic [W-1:0] s1_y;
  logic         s1_op;

  // handshake controls
  logic s1_load;
  logic s2_load;

  // combinational results computed from the capture stage
  logic [W-2:0]  mag_x;
  logic [W-2:0]  mag_y;
  logic          x_ge_y;
  logic [W-2:0]  dmp;
  logic [W-2:0]  dmp_min;
  logic [EW-1:0] exp_diff;
  logic          real_op;
  logic          zero_flag;
  logic          sign_res;
  logic          special;

  // S2 may load when it is empty or its result leaves this edge; S1 refills when it drains
  always_comb begin
    s2_load    = s1_valid & (~out_valid_o | out_ready_i);
    in_ready_o = rst & (~s1_valid | s2_load);
    s1_load    = in_valid_i & in_ready_o;
  end

  // order operands by magnitude and derive effective operation, sign and flags
  always_comb begin
    mag_x     = s1_x[W-2:0];
    mag_y     = s1_y[W-2:0];
    x_ge_y    = (mag_x >= mag_y);
    real_op   = s1_op ^ s1_x[W-1] ^ s1_y[W-1];
    dmp       = x_ge_y ? mag_x : mag_y;
    dmp_min   = x_ge_y ? mag_y : mag_x;
    // magnitude ordering guarantees the exponent difference never wraps
    exp_diff  = dmp[W-2:W-1-EW] - dmp_min[W-2:W-1-EW];
    // equal magnitudes under effective subtraction cancel exactly; result is +0
    zero_flag = real_op & (mag_x == mag_y);
    sign_res  = x_ge_y ? s1_x[W-1] : (s1_y[W-1] ^ s1_op);
    if (zero_flag) begin
      sign_res = 1'b0;
    end
    special   = (&s1_x[W-2:W-1-EW]) | (&s1_y[W-2:W-1-EW]);
  end

  // capture register: holds one accepted operand set until S2 takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_op    <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_x     <= Data_X_i;
        s1_y     <= Data_Y_i;
        s1_op    <= add_subt_i;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // result register: outputs stay frozen while valid and not accepted downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o         <= 1'b0;
      DMP_o               <= '0;
      DmP_o               <= '0;
      exp_diff_o          <= '0;
      zero_flag_o         <= 1'b0;
      real_op_o           <= 1'b0;
      sign_final_result_o <= 1'b0;
      special_o           <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid_o         <= 1'b1;
        DMP_o               <= dmp;
        DmP_o               <= dmp_min;
        exp_diff_o          <= exp_diff;
        zero_flag_o         <= zero_flag;
        real_op_o           <= real_op;
        sign_final_result_o <= sign_res;
        special_o           <= special;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_oper_start_in_pipe.sv
// tb/tb_oper_start_in_pipe.sv - directed self-checking bench for oper_start_in_pipe
module tb_oper_start_in_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // single precision instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        add_subt = 1'b0;
  logic [31:0] dx = '0;
  logic [31:0] dy = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [30:0] dmp, dmp_min;
  logic [7:0]  exp_diff;
  logic        zero_flag, real_op, sign_res, special;

  // double precision instance
  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic        add_subt64 = 1'b0;
  logic [63:0] dx64 = '0;
  logic [63:0] dy64 = '0;
  logic        out_valid64;
  logic        out_ready64 = 1'b0;
  logic [62:0] dmp64, dmp_min64;
  logic [10:0] exp_diff64;
  logic        zero_flag64, real_op64, sign_res64, special64;

  oper_start_in_pipe #(.W(32), .EW(8)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .add_subt_i(add_subt), .Data_X_i(dx), .Data_Y_i(dy),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .DMP_o(dmp), .DmP_o(dmp_min), .exp_diff_o(exp_diff),
    .zero_flag_o(zero_flag), .real_op_o(real_op),
    .sign_final_result_o(sign_res), .special_o(special)
  );

  oper_start_in_pipe #(.W(64), .EW(11)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid64), .in_ready_o(in_ready64),
    .add_subt_i(add_subt64), .Data_X_i(dx64), .Data_Y_i(dy64),
    .out_valid_o(out_valid64), .out_ready_i(out_ready64),
    .DMP_o(dmp64), .DmP_o(dmp_min64), .exp_diff_o(exp_diff64),
    .zero_flag_o(zero_flag64), .real_op_o(real_op64),
    .sign_final_result_o(sign_res64), .special_o(special64)
  );

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++;
    if ({dmp, dmp_min, exp_diff} !== '0) begin n_errors++; $display("FAIL reset_data: got %h %h %h expected zeros", dmp, dmp_min, exp_diff); end
    n_checks++;
    if ({zero_flag, real_op, sign_res, special} !== 4'b0) begin n_errors++; $display("FAIL reset_flags: got %b expected 0000", {zero_flag, real_op, sign_res, special}); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || in_ready64 !== 1'b1) begin n_errors++; $display("FAIL release_in_ready: got %b/%b expected 1/1", in_ready, in_ready64); end
  endtask

  // one operation, result held (out_ready=0) and checked two edges after acceptance
  task automatic test_op(input string name, input logic [31:0] x, input logic [31:0] y, input logic op,
                         input logic [30:0] e_dmp, input logic [30:0] e_dmin, input logic [7:0] e_exp,
                         input logic e_zero, input logic e_real, input logic e_sign, input logic e_special);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; dx = x; dy = y; add_subt = op;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0; dx = '0; dy = '0; add_subt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL %s_out_valid: got %b expected 1", name, out_valid); end
    n_checks++;
    if (dmp !== e_dmp) begin n_errors++; $display("FAIL %s_DMP: got %h expected %h", name, dmp, e_dmp); end
    n_checks++;
    if (dmp_min !== e_dmin) begin n_errors++; $display("FAIL %s_DmP: got %h expected %h", name, dmp_min, e_dmin); end
    n_checks++;
    if (exp_diff !== e_exp) begin n_errors++; $display("FAIL %s_exp_diff: got %0d expected %0d", name, exp_diff, e_exp); end
    n_checks++;
    if ({zero_flag, real_op, sign_res, special} !== {e_zero, e_real, e_sign, e_special})
      begin n_errors++; $display("FAIL %s_flags(zero,real,sign,special): got %b expected %b", name,
        {zero_flag, real_op, sign_res, special}, {e_zero, e_real, e_sign, e_special}); end
  endtask

  // drain the held result so the next test starts empty
  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] bx [4];
    logic [31:0] by [4];
    logic [30:0] bd [4];
    int acc;
    int got;
    bx[0] = 32'h3F800000; by[0] = 32'h40000000; bd[0] = 31'h40000000;
    bx[1] = 32'h40800000; by[1] = 32'h3F800000; bd[1] = 31'h40800000;
    bx[2] = 32'h41000000; by[2] = 32'h41200000; bd[2] = 31'h41200000;
    bx[3] = 32'h3F000000; by[3] = 32'h3E800000; bd[3] = 31'h3F000000;
    acc = 0;
    got = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (acc < 4) begin
        in_valid = 1'b1; dx = bx[acc]; dy = by[acc]; add_subt = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        n_checks++;
        if (acc !== 2 || in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_drop: got accepts=%0d in_ready=%b expected 2/0", acc, in_ready); end
      end
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if (out_valid !== 1'b1 || dmp !== bd[0]) begin n_errors++; $display("FAIL bp_hold_cyc%0d: got valid=%b DMP=%h expected 1/%h", cyc, out_valid, dmp, bd[0]); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (got >= 4) begin
          n_errors++; $display("FAIL bp_extra_result: got result #%0d expected only 4", got);
        end else if (dmp !== bd[got]) begin
          n_errors++; $display("FAIL bp_order_%0d: got DMP=%h expected %h", got, dmp, bd[got]);
        end
        got++;
      end
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (acc !== 4 || got !== 4) begin n_errors++; $display("FAIL bp_count: got accepts=%0d results=%0d expected 4/4", acc, got); end
  endtask

  task automatic test_special_reset;
    int seen;
    test_op("special", 32'h7F800000, 32'h3F800000, 1'b0,
            31'h7F800000, 31'h3F800000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b1);
    // a second operation left in flight in S1 when reset hits
    @(negedge clk);
    in_valid = 1'b1; dx = 32'h40000000; dy = 32'h3F800000; add_subt = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_async: got valid=%b ready=%b expected 0/0", out_valid, in_ready); end
    n_checks++;
    if (dmp !== '0 || special !== 1'b0) begin n_errors++; $display("FAIL rst_clear: got DMP=%h special=%b expected 0/0", dmp, special); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (seen !== 0) begin n_errors++; $display("FAIL rst_no_ghost: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_double;
    @(negedge clk);
    out_ready64 = 1'b0;
    in_valid64 = 1'b1; dx64 = 64'h4008000000000000; dy64 = 64'h3FF0000000000000; add_subt64 = 1'b0;
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid64 !== 1'b1) begin n_errors++; $display("FAIL dp_out_valid: got %b expected 1", out_valid64); end
    n_checks++;
    if (dmp64 !== 63'h4008000000000000) begin n_errors++; $display("FAIL dp_DMP: got %h expected 4008000000000000", dmp64); end
    n_checks++;
    if (dmp_min64 !== 63'h3FF0000000000000) begin n_errors++; $display("FAIL dp_DmP: got %h expected 3ff0000000000000", dmp_min64); end
    n_checks++;
    if (exp_diff64 !== 11'd1 || real_op64 !== 1'b0) begin n_errors++; $display("FAIL dp_exp_real: got %0d/%b expected 1/0", exp_diff64, real_op64); end
  endtask

  initial begin
    test_reset();
    test_op("order", 32'h40400000, 32'h3F800000, 1'b0, 31'h40400000, 31'h3F800000, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    test_op("swap_sub", 32'h3F800000, 32'hC0400000, 1'b0, 31'h40400000, 31'h3F800000, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    test_op("exact_zero", 32'h40A00000, 32'h40A00000, 1'b1, 31'h40A00000, 31'h40A00000, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    test_op("tie_add", 32'hC0A00000, 32'hC0A00000, 1'b0, 31'h40A00000, 31'h40A00000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    test_op("swap_subop", 32'h3F800000, 32'h40400000, 1'b1, 31'h40400000, 31'h3F800000, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    test_back_to_back();
    test_special_reset();
    test_double();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
